// File: rtl/ps2_host_ctrl.sv
// rtl/ps2_host_ctrl.sv - PS/2 host-to-device command sequencer with resend retry and timeout
module ps2_host_ctrl #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_inhibit,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_RTS     = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_LACK    = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERROR   = 3'd7;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [9:0]    frame;
  logic          data_drv;
  logic [7:0]    cur_byte;
  logic [7:0]    arg_byte;
  logic          has_arg;
  logic          second;
  logic [RW-1:0] retry;
  logic [1:0]    code;
  logic [1:0]    clk_s;
  logic [1:0]    data_s;
  logic          clk_d;
  logic          fe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s  <= 2'b11;
      data_s <= 2'b11;
      clk_d  <= 1'b1;
    end else begin
      clk_s  <= {clk_s[0], ps2clk};
      data_s <= {data_s[0], ps2data};
      clk_d  <= clk_s[1];
    end
  end

  assign fe = clk_d & ~clk_s[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      frame    <= '0;
      data_drv <= 1'b0;
      cur_byte <= '0;
      arg_byte <= '0;
      has_arg  <= 1'b0;
      second   <= 1'b0;
      retry    <= '0;
      code     <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cur_byte <= cmd_byte;
            arg_byte <= cmd_arg;
            has_arg  <= cmd_has_arg;
            second   <= 1'b0;
            retry    <= '0;
            code     <= 2'b00;
            cnt      <= '0;
            state    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
            cnt      <= '0;
            frame    <= {1'b1, ~^cur_byte, cur_byte};
            bit_idx  <= '0;
            data_drv <= 1'b1;
            state    <= S_RTS;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RTS: begin
          cnt   <= '0;
          state <= S_SEND;
        end
        S_SEND, S_LACK, S_WAIT: begin
          // One timeout window covers the frame, the line ACK and the response byte
          if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            code  <= 2'b01;
            state <= S_ERROR;
          end else begin
            cnt <= cnt + CW'(1);
            if (state == S_SEND) begin
              if (fe) begin
                data_drv <= ~frame[0];
                frame    <= frame >> 1;
                bit_idx  <= bit_idx + 4'd1;
                if (bit_idx == 4'd9) state <= S_LACK;
              end
            end else if (state == S_LACK) begin
              if (fe) begin
                if (!data_s[1]) begin
                  state <= S_WAIT;
                end else begin
                  code  <= 2'b11;
                  state <= S_ERROR;
                end
              end
            end else if (rx_valid) begin
              if (rx_byte == 8'hFA) begin
                if (!second && has_arg) begin
                  cur_byte <= arg_byte;
                  second   <= 1'b1;
                  retry    <= '0;
                  cnt      <= '0;
                  state    <= S_INHIBIT;
                end else begin
                  state <= S_DONE;
                end
              end else if (rx_byte == 8'hFE) begin
                if (retry < RW'(MAX_RETRY)) begin
                  retry <= retry + RW'(1);
                  cnt   <= '0;
                  state <= S_INHIBIT;
                end else begin
                  code  <= 2'b10;
                  state <= S_ERROR;
                end
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pad enables decode straight from state so reset releases the lines immediately
  assign ps2clk_oe  = (state == S_INHIBIT) || (state == S_RTS);
  assign ps2data_oe = (state == S_RTS) || ((state == S_SEND) && data_drv);
  assign rx_inhibit = (state == S_INHIBIT) || (state == S_RTS) || (state == S_SEND) || (state == S_LACK);
  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign err        = (state == S_ERROR);
  assign err_code   = code;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// tb/tb_ps2_host_ctrl.sv - directed bench with a behavioural PS/2 keyboard for ps2_host_ctrl
module tb_ps2_host_ctrl;

  localparam int INH = 50;
  localparam int TO  = 1000;
  localparam int MR  = 3;
  localparam int H   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2clk, ps2data, ps2clk_oe, ps2data_oe;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_has_arg = 1'b0;
  logic [7:0] cmd_byte = 8'h00, cmd_arg = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_inhibit, busy, done, err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  // Open-drain lines with pull-ups: low if either side pulls
  assign ps2clk  = dev_clk & ~ps2clk_oe;
  assign ps2data = dev_data & ~ps2data_oe;

  ps2_host_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .ps2clk(ps2clk), .ps2data(ps2data),
    .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte),
    .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_inhibit(rx_inhibit),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  int         n_checks = 0, n_fail = 0;
  int         cyc = 0, done_cnt = 0, err_cnt = 0, busy_bad = 0, run = 0;
  int         send_entry = 0, err_cyc = 0;
  logic [1:0] last_code = 2'b00, err_oe = 2'b00;
  logic       prev_done = 1'b0, prev_clk_oe = 1'b0;
  int         inh_q[$];

  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (prev_done && (busy || done)) busy_bad++;
    prev_done = done;
    if (err) begin
      err_cnt++;
      last_code = err_code;
      err_cyc = cyc;
      err_oe = {ps2clk_oe, ps2data_oe};
    end
    if (prev_clk_oe && !ps2clk_oe && ps2data_oe) send_entry = cyc;
    prev_clk_oe = ps2clk_oe;
    if (ps2clk_oe && !ps2data_oe) run++;
    else if (run > 0) begin
      inh_q.push_back(run);
      run = 0;
    end
  end

  task automatic issue(input logic [7:0] b, input logic ha, input logic [7:0] a);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_byte = b; cmd_has_arg = ha; cmd_arg = a;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_byte = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Keyboard model: waits for request-to-send, clocks edges, samples host bits on rising edges
  task automatic dev_frame(input int edges, input bit ack, output logic [9:0] bits, output bit ok);
    int w;
    bits = '0; ok = 1'b0; w = 0;
    while (!(ps2data_oe && !ps2clk_oe) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w < 3000) begin
      ok = 1'b1;
      repeat (H) @(negedge clk);
      for (int e = 1; e <= edges; e++) begin
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
        if (e <= 10) bits[e-1] = ps2data;
        if (e == 10 && ack) dev_data = 1'b0;
        repeat (H) @(negedge clk);
      end
      dev_data = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_ready, busy, done, err} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_status got %b exp 1000", {cmd_ready, busy, done, err});
    end
    n_checks++;
    if ({ps2clk_oe, ps2data_oe, rx_inhibit} !== 3'b000) begin
      n_fail++; $display("FAIL reset_lines got %b exp 000", {ps2clk_oe, ps2data_oe, rx_inhibit});
    end
    n_checks++;
    if (err_code !== 2'b00) begin
      n_fail++; $display("FAIL reset_err_code got %b exp 00", err_code);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [9:0] bits; bit ok; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    issue(8'hF4, 1'b0, 8'h00);
    n_checks++;
    if ({busy, cmd_ready, rx_inhibit, ps2clk_oe} !== 4'b1011) begin
      n_fail++; $display("FAIL accept_state got %b exp 1011", {busy, cmd_ready, rx_inhibit, ps2clk_oe});
    end
    dev_frame(11, 1'b1, bits, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL f4_rts got 0 exp 1"); end
    n_checks++;
    if (bits !== 10'h2F4) begin n_fail++; $display("FAIL f4_frame got %h exp 2f4", bits); end
    n_checks++;
    if ({rx_inhibit, busy} !== 2'b01) begin
      n_fail++; $display("FAIL wait_resp_inhibit got %b exp 01", {rx_inhibit, busy});
    end
    send_rx(8'hFA);
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL f4_done got %0d exp 1", done_cnt - d0); end
    n_checks++;
    if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL f4_no_err got %0d exp 0", err_cnt - e0); end
    n_checks++;
    if (busy_bad !== 0) begin n_fail++; $display("FAIL busy_after_done got %0d exp 0", busy_bad); end
    n_checks++;
    if ({busy, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL f4_idle got %b exp 01", {busy, cmd_ready}); end
  endtask

  task automatic test_two_byte();
    logic [9:0] bits; bit ok; int d0;
    d0 = done_cnt;
    inh_q.delete();
    issue(8'hED, 1'b1, 8'h02);
    dev_frame(11, 1'b1, bits, ok);
    n_checks++;
    if (!ok || bits !== 10'h3ED) begin n_fail++; $display("FAIL ed_frame got %h exp 3ed", bits); end
    send_rx(8'hFA);
    dev_frame(11, 1'b1, bits, ok);
    n_checks++;
    if (!ok || bits !== 10'h202) begin n_fail++; $display("FAIL arg_frame got %h exp 202", bits); end
    send_rx(8'hFA);
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL two_byte_done got %0d exp 1", done_cnt - d0); end
    n_checks++;
    if (inh_q.size() !== 2) begin n_fail++; $display("FAIL inhibit_phases got %0d exp 2", inh_q.size()); end
    for (int i = 0; i < inh_q.size(); i++) begin
      n_checks++;
      if (inh_q[i] !== INH) begin n_fail++; $display("FAIL inhibit_len%0d got %0d exp %0d", i, inh_q[i], INH); end
    end
  endtask

  task automatic test_resend();
    logic [9:0] bits; bit ok; int d0, e0;
    d0 = done_cnt;
    issue(8'hED, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      dev_frame(11, 1'b1, bits, ok);
      n_checks++;
      if (!ok || bits !== 10'h3ED) begin n_fail++; $display("FAIL resend_frame%0d got %h exp 3ed", k, bits); end
      send_rx((k < 2) ? 8'hFE : 8'hFA);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL resend_done got %0d exp 1", done_cnt - d0); end
    d0 = done_cnt; e0 = err_cnt;
    issue(8'hED, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      dev_frame(11, 1'b1, bits, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL exhaust_rts%0d got 0 exp 1", k); end
      send_rx(8'hFE);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (err_cnt - e0 !== 1 || last_code !== 2'b10) begin
      n_fail++; $display("FAIL retry_exhaust got err %0d code %b exp err 1 code 10", err_cnt - e0, last_code);
    end
    n_checks++;
    if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL exhaust_no_done got %0d exp 0", done_cnt - d0); end
  endtask

  task automatic test_timeout();
    logic [9:0] bits; bit ok; int e0, w;
    e0 = err_cnt;
    issue(8'hF4, 1'b0, 8'h00);
    dev_frame(5, 1'b0, bits, ok);
    w = 0;
    while (err_cnt == e0 && w < 2 * TO) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (err_cnt - e0 !== 1 || last_code !== 2'b01) begin
      n_fail++; $display("FAIL timeout_err got err %0d code %b exp err 1 code 01", err_cnt - e0, last_code);
    end
    n_checks++;
    if (err_cyc - send_entry !== TO) begin
      n_fail++; $display("FAIL timeout_latency got %0d exp %0d", err_cyc - send_entry, TO);
    end
    n_checks++;
    if (err_oe !== 2'b00) begin n_fail++; $display("FAIL timeout_release got %b exp 00", err_oe); end
  endtask

  task automatic test_no_line_ack();
    logic [9:0] bits; bit ok; int e0;
    e0 = err_cnt;
    issue(8'hF4, 1'b0, 8'h00);
    dev_frame(11, 1'b0, bits, ok);
    repeat (5) @(negedge clk);
    n_checks++;
    if (!ok || bits !== 10'h2F4) begin n_fail++; $display("FAIL nolack_frame got %h exp 2f4", bits); end
    n_checks++;
    if (err_cnt - e0 !== 1 || last_code !== 2'b11) begin
      n_fail++; $display("FAIL no_line_ack got err %0d code %b exp err 1 code 11", err_cnt - e0, last_code);
    end
  endtask

  task automatic test_ignore();
    logic [9:0] bits; bit ok; int d0;
    d0 = done_cnt;
    issue(8'hF4, 1'b0, 8'h00);
    send_rx(8'hFA);
    dev_frame(11, 1'b1, bits, ok);
    n_checks++;
    if (!ok || bits !== 10'h2F4) begin n_fail++; $display("FAIL ignore_frame got %h exp 2f4", bits); end
    send_rx(8'h1C);
    repeat (10) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL scan_code_ignored got done %0d busy %b exp done 0 busy 1", done_cnt - d0, busy);
    end
    issue(8'h55, 1'b0, 8'h00);
    send_rx(8'hFA);
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ignore_done got %0d exp 1", done_cnt - d0); end
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_cmd_not_queued got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits; bit ok; int d0;
    issue(8'hF4, 1'b0, 8'h00);
    dev_frame(4, 1'b0, bits, ok);
    #3;
    n_checks++;
    if (ps2data_oe !== 1'b1) begin n_fail++; $display("FAIL mid_frame_bit3 got %b exp 1", ps2data_oe); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ps2clk_oe, ps2data_oe, cmd_ready, busy} !== 4'b0010) begin
      n_fail++; $display("FAIL async_reset got %b exp 0010", {ps2clk_oe, ps2data_oe, cmd_ready, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    issue(8'hF4, 1'b0, 8'h00);
    dev_frame(11, 1'b1, bits, ok);
    send_rx(8'hFA);
    repeat (5) @(negedge clk);
    n_checks++;
    if (!ok || bits !== 10'h2F4 || done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL post_reset_cmd got frame %h done %0d exp 2f4 1", bits, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_two_byte();
    test_resend();
    test_timeout();
    test_no_line_ack();
    test_ignore();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_ctrl.md
Name: ps2_host_ctrl

Overview:
- Host-to-device command sequencer for the PS/2 keyboard port. Sends 1- or 2-byte commands to the keyboard, e.g. 0xED + LED mask or 0xF3 + typematic rate.
- Drives the open-drain clock/data lines, performs the PS/2 request-to-send and the 11-edge transmit frame, then waits for the keyboard response byte.
- Takes response bytes from the existing scan-code receiver path. Retries on 0xFE (resend) and reports errors.
- Holds off the scan-code receiver while it owns the bus.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles ps2clk is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, max clk cycles per byte from request-to-send to response byte (15 ms at 50 MHz).
- MAX_RETRY, 3, resend attempts per byte after 0xFE before error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ps2clk  in  1  raw PS/2 clock line (pad input)
- ps2data  in  1  raw PS/2 data line (pad input)
- ps2clk_oe  out  1  1 = pull PS/2 clock low, 0 = release
- ps2data_oe  out  1  1 = pull PS/2 data low, 0 = release
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller idle, command accepted when valid&ready
- cmd_byte  in  8  first command byte
- cmd_has_arg  in  1  1 = send cmd_arg after ACK of cmd_byte
- cmd_arg  in  8  argument byte
- rx_valid  in  1  one-cycle pulse, response byte available from receiver
- rx_byte  in  8  received byte
- rx_inhibit  out  1  1 = receiver must ignore line activity
- busy  out  1  command in progress
- done  out  1  one-cycle pulse, command fully acknowledged
- err  out  1  one-cycle pulse, command aborted
- err_code  out  2  valid with err: 01 timeout, 10 retries exhausted, 11 no line-ACK

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; ps2clk_oe=0, ps2data_oe=0 (lines released immediately, even mid-frame).
  - cmd_ready=1, busy=0, done=0, err=0, err_code=00, rx_inhibit=0; all counters 0.
- Input conditioning: ps2clk and ps2data pass through 2-FF synchronisers. A falling edge (fe) is synced clock 1 in the previous cycle and 0 now.
- cmd_ready=1 only in IDLE. On accept, latch cmd_byte, cmd_has_arg, cmd_arg. The cycle after accept: busy=1, cmd_ready=0. cur_byte=cmd_byte, retry=0.
- States:
  - IDLE: accept command -> INHIBIT.
  - INHIBIT: ps2clk_oe=1, rx_inhibit=1. Count INHIBIT_CYCLES. Then ps2data_oe=1 (start bit), and one cycle later ps2clk_oe=0 -> SEND. Timeout counter starts at the entry to SEND.
  - SEND: bit index n=0..9. On each fe, drive bit n: data LSB first, n=8 odd parity (ps2data_oe = ~bit), n=9 stop (ps2data_oe=0). After n=9 is driven -> LACK.
  - LACK: on the next fe, sample synced ps2data. 0 -> WAIT_RESP. 1 -> ERROR code 11.
  - WAIT_RESP: rx_inhibit=0. On rx_valid:
    - 0xFA: if first byte and has_arg, cur_byte=cmd_arg, retry=0 -> INHIBIT; otherwise -> DONE.
    - 0xFE: if retry<MAX_RETRY, retry++, resend cur_byte -> INHIBIT; otherwise -> ERROR code 10.
    - Any other byte is ignored (scan code in flight).
  - DONE: done=1 for 1 cycle, busy=0 -> IDLE.
  - ERROR: err=1 for 1 cycle, err_code holds until the next command accept, lines released -> IDLE.
- Timeout: a per-byte counter runs from entry to SEND through WAIT_RESP and clears on each new byte or resend. Reaching TIMEOUT_CYCLES in any of those states -> ERROR code 01, lines released the same cycle.
- rx_valid outside WAIT_RESP is ignored. A cmd_valid pulse while busy is not accepted and not queued.
- An fe during INHIBIT is ignored, since the host holds the clock.

Test Plan:
- cmd 0xF4, has_arg=0. Device clocks 11 edges, pulls data low on edge 11, then rx 0xFA -> 10 bits observed as 0,0,1,0,1,1,1,1 (LSB-first 0xF4), parity 0, stop released. done pulses once; busy drops the next cycle.
- cmd 0xED, arg 0x02. ACK 0xFA after each byte -> two INHIBIT phases of exactly INHIBIT_CYCLES each. Second frame carries 0x02 with parity 0. Single done pulse.
- cmd 0xED. Device answers 0xFE twice, then 0xFA -> 0xED is transmitted 3 times, then done. With 4 consecutive 0xFE -> err=1, err_code=10 after the 4th.
- Device stops clocking after 5 edges -> err=1, err_code=01 exactly TIMEOUT_CYCLES after SEND entry. Both oe outputs are 0 in the same cycle.
- ps2data held high on edge 11 -> err_code=11. rx 0x1C arriving in WAIT_RESP before 0xFA is ignored, then done.
- rst_n asserted during SEND bit 4 -> ps2clk_oe=ps2data_oe=0 asynchronously. After release: IDLE, cmd_ready=1, new command succeeds.
